// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU between two requesters. A request is
// accepted in IDLE, its operands are latched and driven to the ALU, the ALU
// result is captured during EXEC, and the result is offered to the winning
// requester in RESP until it is consumed.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   req_valid0/1, req_ready0/1    request handshake per requester
//   req_in1_0/1, req_in2_0/1      32-bit operands per requester
//   req_ct_0/1, req_shamt_0/1     ALU control code and shift amount
//   req_sign_0/1                  signed-compare select
//   rsp_valid0/1, rsp_ready0/1    response handshake per requester
//   rsp_data, rsp_zero            registered ALU result and zero flag
//   alu_in1/in2/ct/shamt/sign     operands to the shared ALU
//   alu_out, alu_zero             result from the shared ALU
//   busy                          high whenever an operation is in flight
// Parameter
//   FIXED_PRIO   0 = round-robin on ties, 1 = port 0 wins every tie
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid0,
   input  logic        req_valid1,
   output logic        req_ready0,
   output logic        req_ready1,
   input  logic [31:0] req_in1_0,
   input  logic [31:0] req_in1_1,
   input  logic [31:0] req_in2_0,
   input  logic [31:0] req_in2_1,
   input  logic [4:0]  req_ct_0,
   input  logic [4:0]  req_ct_1,
   input  logic [4:0]  req_shamt_0,
   input  logic [4:0]  req_shamt_1,
   input  logic        req_sign_0,
   input  logic        req_sign_1,
   output logic        rsp_valid0,
   output logic        rsp_valid1,
   input  logic        rsp_ready0,
   input  logic        rsp_ready1,
   output logic [31:0] rsp_data,
   output logic        rsp_zero,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [4:0]  alu_ct,
   output logic [4:0]  alu_shamt,
   output logic        alu_sign,
   input  logic [31:0] alu_out,
   input  logic        alu_zero,
   output logic        busy
);

   localparam bit ROUND_ROBIN = (FIXED_PRIO == 0);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state_q;
   logic        last_q;        // port granted most recently (1 = port 1)
   logic        grant_q;       // port owning the operation in flight
   logic [31:0] op_in1_q, op_in2_q;
   logic [4:0]  op_ct_q, op_shamt_q;
   logic        op_sign_q;
   logic [31:0] rsp_data_q;
   logic        rsp_zero_q;
   logic        rsp_valid0_q, rsp_valid1_q;
   logic        busy_q;

   logic        any_valid;
   logic        grant1;
   logic        accept;
   logic        rsp_take;
   logic [31:0] op_in1_d, op_in2_d;
   logic [4:0]  op_ct_d, op_shamt_d;
   logic        op_sign_d;

   // Port 1 wins when it is the only requester, or on a tie when round-robin
   // and port 0 was served last. last_q resets to 1 so the first tie goes to 0.
   assign any_valid = req_valid0 | req_valid1;
   assign grant1    = req_valid1 & (~req_valid0 | (ROUND_ROBIN & ~last_q));
   // Reset gates the combinational ready so nothing is accepted while held.
   assign accept    = (state_q == IDLE) & any_valid & ~reset;

   assign req_ready0 = accept & ~grant1;
   assign req_ready1 = accept & grant1;

   // Only the owning port's rsp_ready can release the result.
   assign rsp_take = grant_q ? rsp_ready1 : rsp_ready0;

   always_comb begin
      op_in1_d   = req_in1_0;
      op_in2_d   = req_in2_0;
      op_ct_d    = req_ct_0;
      op_shamt_d = req_shamt_0;
      op_sign_d  = req_sign_0;
      if (grant1) begin
         op_in1_d   = req_in1_1;
         op_in2_d   = req_in2_1;
         op_ct_d    = req_ct_1;
         op_shamt_d = req_shamt_1;
         op_sign_d  = req_sign_1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_q       <= 1'b1;
         grant_q      <= 1'b0;
         op_in1_q     <= '0;
         op_in2_q     <= '0;
         op_ct_q      <= '0;
         op_shamt_q   <= '0;
         op_sign_q    <= 1'b0;
         rsp_data_q   <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_valid0_q <= 1'b0;
         rsp_valid1_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  grant_q    <= grant1;
                  last_q     <= grant1;
                  op_in1_q   <= op_in1_d;
                  op_in2_q   <= op_in2_d;
                  op_ct_q    <= op_ct_d;
                  op_shamt_q <= op_shamt_d;
                  op_sign_q  <= op_sign_d;
                  busy_q     <= 1'b1;
                  state_q    <= EXEC;
               end
            end
            EXEC: begin
               rsp_data_q   <= alu_out;
               rsp_zero_q   <= alu_zero;
               rsp_valid0_q <= ~grant_q;
               rsp_valid1_q <= grant_q;
               state_q      <= RESP;
            end
            RESP: begin
               if (rsp_take) begin
                  rsp_valid0_q <= 1'b0;
                  rsp_valid1_q <= 1'b0;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign alu_in1    = op_in1_q;
   assign alu_in2    = op_in2_q;
   assign alu_ct     = op_ct_q;
   assign alu_shamt  = op_shamt_q;
   assign alu_sign   = op_sign_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_valid0 = rsp_valid0_q;
   assign rsp_valid1 = rsp_valid1_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Two arbiters side by side (index 0: round-robin, index 1: fixed priority)
// share stimulus; each drives its own copy of a behavioural ALU. Directed
// table vectors, hand-written multi-cycle sequences, then randomized traffic
// checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req_valid0, req_valid1, rsp_ready0, rsp_ready1;
   logic [31:0] in1_0, in1_1, in2_0, in2_1;
   logic [4:0]  ct_0, ct_1, sh_0, sh_1;
   logic        sg_0, sg_1;

   logic        req_ready0_w [2];
   logic        req_ready1_w [2];
   logic        rsp_valid0_w [2];
   logic        rsp_valid1_w [2];
   logic        rsp_zero_w   [2];
   logic        busy_w       [2];
   logic        alu_sign_w   [2];
   logic        alu_zero_w   [2];
   logic [31:0] rsp_data_w   [2];
   logic [31:0] alu_in1_w    [2];
   logic [31:0] alu_in2_w    [2];
   logic [31:0] alu_out_w    [2];
   logic [4:0]  alu_ct_w     [2];
   logic [4:0]  alu_shamt_w  [2];

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural shared ALU: 0 and, 1 or, 2 add, 6 sub, 7 slt, 8 sll, 9 srl.
   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] ct, input logic [4:0] sh,
                                         input logic sg);
      logic [31:0] r;
      case (ct)
         5'd0: r = a & b;
         5'd1: r = a | b;
         5'd2: r = a + b;
         5'd6: r = a - b;
         5'd7: r = sg ? {31'd0, ($signed(a) < $signed(b))} : {31'd0, (a < b)};
         5'd8: r = a << sh;
         5'd9: r = a >> sh;
         default: r = a ^ b;
      endcase
      return r;
   endfunction

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         alu_arbiter #(.FIXED_PRIO(gi)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid0 (req_valid0),
            .req_valid1 (req_valid1),
            .req_ready0 (req_ready0_w[gi]),
            .req_ready1 (req_ready1_w[gi]),
            .req_in1_0  (in1_0),
            .req_in1_1  (in1_1),
            .req_in2_0  (in2_0),
            .req_in2_1  (in2_1),
            .req_ct_0   (ct_0),
            .req_ct_1   (ct_1),
            .req_shamt_0(sh_0),
            .req_shamt_1(sh_1),
            .req_sign_0 (sg_0),
            .req_sign_1 (sg_1),
            .rsp_valid0 (rsp_valid0_w[gi]),
            .rsp_valid1 (rsp_valid1_w[gi]),
            .rsp_ready0 (rsp_ready0),
            .rsp_ready1 (rsp_ready1),
            .rsp_data   (rsp_data_w[gi]),
            .rsp_zero   (rsp_zero_w[gi]),
            .alu_in1    (alu_in1_w[gi]),
            .alu_in2    (alu_in2_w[gi]),
            .alu_ct     (alu_ct_w[gi]),
            .alu_shamt  (alu_shamt_w[gi]),
            .alu_sign   (alu_sign_w[gi]),
            .alu_out    (alu_out_w[gi]),
            .alu_zero   (alu_zero_w[gi]),
            .busy       (busy_w[gi])
         );
         assign alu_out_w[gi]  = alu_f(alu_in1_w[gi], alu_in2_w[gi], alu_ct_w[gi],
                                       alu_shamt_w[gi], alu_sign_w[gi]);
         assign alu_zero_w[gi] = (alu_out_w[gi] == 32'd0);
      end
   endgenerate

   // {req_ready0, req_ready1, rsp_valid0, rsp_valid1, busy}
   function automatic logic [4:0] flags(input int d);
      return {req_ready0_w[d], req_ready1_w[d], rsp_valid0_w[d], rsp_valid1_w[d], busy_w[d]};
   endfunction

   task automatic chk(input string name, input int d, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got 0x%0h, want 0x%0h", name, d, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic rand_operands();
      logic [4:0] cts [7];
      cts = '{5'd0, 5'd1, 5'd2, 5'd6, 5'd7, 5'd8, 5'd9};
      in1_0 = $urandom; in2_0 = $urandom; in1_1 = $urandom; in2_1 = $urandom;
      ct_0 = cts[$urandom_range(0, 6)]; ct_1 = cts[$urandom_range(0, 6)];
      sh_0 = 5'($urandom); sh_1 = 5'($urandom);
      sg_0 = 1'($urandom); sg_1 = 1'($urandom);
   endtask

   typedef struct {
      int          port;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  ct;
      logic [4:0]  sh;
      logic        sg;
      logic [31:0] exp;
      logic        z;
   } vec_t;

   vec_t tv [8];

   // Reference model state, one per instance.
   int          m_busy  [2];
   int          m_phase [2];   // 0 = result not yet offered, 1 = offered
   int          m_port  [2];
   int          m_last  [2];
   logic [31:0] m_data  [2];
   logic        m_zero  [2];

   initial begin
      int win, any;
      logic [4:0] ef;
      int gq0 [$];
      int gq1 [$];

      reset = 1'b1;
      req_valid0 = 1'b1; req_valid1 = 1'b1;
      rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
      rand_operands();

      tv[0] = '{0, 32'd5,        32'd3,        5'd2, 5'd0,  1'b1, 32'd8,          1'b0};
      tv[1] = '{1, 32'hFFFFFFFF, 32'd1,        5'd7, 5'd0,  1'b1, 32'd1,          1'b0};
      tv[2] = '{1, 32'hFFFFFFFF, 32'd1,        5'd7, 5'd0,  1'b0, 32'd0,          1'b1};
      tv[3] = '{0, 32'd7,        32'd7,        5'd6, 5'd0,  1'b0, 32'd0,          1'b1};
      tv[4] = '{1, 32'hF0F00000, 32'h0FF000FF, 5'd0, 5'd0,  1'b0, 32'h00F00000,   1'b0};
      tv[5] = '{0, 32'h00001234, 32'd5,        5'd8, 5'd4,  1'b0, 32'h00012340,   1'b0};
      tv[6] = '{1, 32'h80000000, 32'd0,        5'd9, 5'd31, 1'b0, 32'd1,          1'b0};
      tv[7] = '{0, 32'h0000000A, 32'h50000000, 5'd1, 5'd0,  1'b0, 32'h5000000A,   1'b0};

      // ---------------- reset state (requests pending while in reset) -------
      @(negedge clk); @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         chk("reset flags", d, 32'(flags(d)), 32'd0);
         chk("reset rsp_data", d, rsp_data_w[d], 32'd0);
         chk("reset rsp_zero", d, 32'(rsp_zero_w[d]), 32'd0);
         chk("reset alu_in1", d, alu_in1_w[d], 32'd0);
         chk("reset alu_in2", d, alu_in2_w[d], 32'd0);
         chk("reset alu_ctl", d, {21'd0, alu_ct_w[d], alu_shamt_w[d], alu_sign_w[d]}, 32'd0);
      end
      do_reset();

      // ---------------- table-driven single-requester operations -----------
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         rand_operands();
         if (tv[k].port == 0) begin
            in1_0 = tv[k].a; in2_0 = tv[k].b; ct_0 = tv[k].ct; sh_0 = tv[k].sh; sg_0 = tv[k].sg;
            req_valid0 = 1'b1;
         end else begin
            in1_1 = tv[k].a; in2_1 = tv[k].b; ct_1 = tv[k].ct; sh_1 = tv[k].sh; sg_1 = tv[k].sg;
            req_valid1 = 1'b1;
         end
         #1;
         for (int d = 0; d < 2; d++)
            chk("tv accept", d, 32'(flags(d)), (tv[k].port == 0) ? 32'b10000 : 32'b01000);
         @(negedge clk);
         req_valid0 = 1'b0; req_valid1 = 1'b0;
         rand_operands();   // operand registers must hold
         #1;
         for (int d = 0; d < 2; d++)
            chk("tv exec", d, 32'(flags(d)), 32'b00001);
         @(negedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            chk("tv resp flags", d, 32'(flags(d)), (tv[k].port == 0) ? 32'b00101 : 32'b00011);
            chk("tv rsp_data", d, rsp_data_w[d], tv[k].exp);
            chk("tv rsp_zero", d, 32'(rsp_zero_w[d]), 32'(tv[k].z));
         end
         $display("vec %0d port%0d ct=%0d -> data=0x%08h zero=%0b (want 0x%08h/%0b)",
                  k, tv[k].port, tv[k].ct, rsp_data_w[0], rsp_zero_w[0], tv[k].exp, tv[k].z);
         if (tv[k].port == 0) rsp_ready0 = 1'b1; else rsp_ready1 = 1'b1;
         @(negedge clk); #1;
         for (int d = 0; d < 2; d++)
            chk("tv done", d, 32'(flags(d)), 32'd0);
         rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
      end

      // ---------------- both ports valid every cycle: 4 grants -------------
      do_reset();
      req_valid0 = 1'b1; req_valid1 = 1'b1;
      rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         for (int d = 0; d < 2; d++) begin
            if (req_ready0_w[d]) begin
               if (d == 0) gq0.push_back(0); else gq1.push_back(0);
            end
            if (req_ready1_w[d]) begin
               if (d == 0) gq0.push_back(1); else gq1.push_back(1);
            end
         end
         @(negedge clk);
      end
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      chk("tie grant count", 0, 32'(gq0.size()), 32'd4);
      chk("tie grant count", 1, 32'(gq1.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk("tie grant rr", 0, (k < gq0.size()) ? 32'(gq0[k]) : 32'hDEAD, 32'(k % 2));
         chk("tie grant fixed", 1, (k < gq1.size()) ? 32'(gq1[k]) : 32'hDEAD, 32'd0);
      end
      $display("tie grants rr=%p fixed=%p", gq0, gq1);

      // ---------------- port 1 stalls its response for 5 cycles ------------
      do_reset();
      in1_1 = 32'd7; in2_1 = 32'd7; ct_1 = 5'd6; sh_1 = 5'd0; sg_1 = 1'b0;
      req_valid1 = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) chk("stall accept1", d, 32'(flags(d)), 32'b01000);
      @(negedge clk);
      req_valid1 = 1'b0; req_valid0 = 1'b1; in1_0 = 32'd9; in2_0 = 32'd1; ct_0 = 5'd2;
      #1;
      for (int d = 0; d < 2; d++) chk("stall exec", d, 32'(flags(d)), 32'b00001);
      @(negedge clk);
      rsp_ready0 = 1'b1;   // wrong port's ready must not release the result
      for (int c = 0; c < 5; c++) begin
         #1;
         for (int d = 0; d < 2; d++) begin
            chk("stall flags", d, 32'(flags(d)), 32'b00011);
            chk("stall rsp_data", d, rsp_data_w[d], 32'd0);
            chk("stall rsp_zero", d, 32'(rsp_zero_w[d]), 32'd1);
         end
         @(negedge clk);
      end
      rsp_ready1 = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) chk("stall release", d, 32'(flags(d)), 32'b00011);
      @(negedge clk);
      rsp_ready1 = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) chk("stall then accept0", d, 32'(flags(d)), 32'b10000);
      $display("stall: port1 held 5 cycles, port0 accepted after release");
      @(negedge clk);
      req_valid0 = 1'b0;
      @(negedge clk); @(negedge clk);

      // ---------------- reset during EXEC ---------------------------------
      do_reset();
      in1_0 = 32'h1234; in2_0 = 32'h1; ct_0 = 5'd2; sh_0 = 5'd3; sg_0 = 1'b1;
      req_valid0 = 1'b1;
      @(negedge clk);     // accepted port 0 at the edge; now in EXEC
      req_valid0 = 1'b0;
      rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) chk("pre-abort alu_in1", d, alu_in1_w[d], 32'h1234);
      reset = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("abort flags", d, 32'(flags(d)), 32'd0);
         chk("abort alu_in1", d, alu_in1_w[d], 32'd0);
         chk("abort alu_ctl", d, {21'd0, alu_ct_w[d], alu_shamt_w[d], alu_sign_w[d]}, 32'd0);
         chk("abort rsp_data", d, rsp_data_w[d], 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         for (int d = 0; d < 2; d++) chk("no response after abort", d, 32'(flags(d)), 32'd0);
         @(negedge clk);
      end
      req_valid0 = 1'b1; req_valid1 = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) chk("post-abort tie", d, 32'(flags(d)), 32'b10000);
      $display("abort: reset in EXEC, next tie granted to port 0");
      @(negedge clk);
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      @(negedge clk); @(negedge clk);

      // ---------------- randomized traffic vs reference model --------------
      do_reset();
      for (int d = 0; d < 2; d++) begin
         m_busy[d] = 0; m_phase[d] = 0; m_port[d] = 0; m_last[d] = 1;
         m_data[d] = '0; m_zero[d] = 1'b0;
      end
      for (int c = 0; c < 400; c++) begin
         rand_operands();
         req_valid0 = ($urandom_range(0, 1) == 1);
         req_valid1 = ($urandom_range(0, 1) == 1);
         rsp_ready0 = ($urandom_range(0, 1) == 1);
         rsp_ready1 = ($urandom_range(0, 1) == 1);
         #1;
         for (int d = 0; d < 2; d++) begin
            any = (req_valid0 || req_valid1) ? 1 : 0;
            if (req_valid0 && req_valid1) win = (d == 1) ? 0 : 1 - m_last[d];
            else win = req_valid1 ? 1 : 0;
            ef[4] = (m_busy[d] == 0) && (any == 1) && (win == 0);
            ef[3] = (m_busy[d] == 0) && (any == 1) && (win == 1);
            ef[2] = (m_busy[d] == 1) && (m_phase[d] == 1) && (m_port[d] == 0);
            ef[1] = (m_busy[d] == 1) && (m_phase[d] == 1) && (m_port[d] == 1);
            ef[0] = (m_busy[d] == 1);
            chk("rnd flags", d, 32'(flags(d)), 32'(ef));
            if (m_busy[d] == 1 && m_phase[d] == 1) begin
               chk("rnd rsp_data", d, rsp_data_w[d], m_data[d]);
               chk("rnd rsp_zero", d, 32'(rsp_zero_w[d]), 32'(m_zero[d]));
            end
            // advance the model across the coming clock edge
            if (m_busy[d] == 0) begin
               if (any == 1) begin
                  m_busy[d] = 1; m_phase[d] = 0; m_port[d] = win; m_last[d] = win;
                  m_data[d] = (win == 0) ? alu_f(in1_0, in2_0, ct_0, sh_0, sg_0)
                                         : alu_f(in1_1, in2_1, ct_1, sh_1, sg_1);
                  m_zero[d] = (m_data[d] == 32'd0);
               end
            end else if (m_phase[d] == 0) begin
               m_phase[d] = 1;
            end else if ((m_port[d] == 0) ? rsp_ready0 : rsp_ready1) begin
               m_busy[d] = 0;
               $display("rnd dut%0d port%0d result 0x%08h consumed at cycle %0d",
                        d, m_port[d], m_data[d], c);
            end
         end
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0, meaning 0 = round-robin arbitration and 1 = port 0 always wins.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: ports clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 req_valid0, req_valid1  input  1 each  requester i presents an operation.
REQ-006 req_ready0, req_ready1  output  1 each  requester i's operation is accepted this cycle.
REQ-007 req_in1_i, req_in2_i  input  32 each  operands of requester i.
REQ-008 req_ct_i  input  5  ALU control code of requester i; req_shamt_i  input  5  shift amount; req_sign_i  input  1  signed-compare select.
REQ-009 rsp_valid0, rsp_valid1  output  1 each  result for requester i is available.
REQ-010 rsp_ready0, rsp_ready1  input  1 each  requester i consumes its result.
REQ-011 rsp_data  output  32  registered ALU result; rsp_zero  output  1  registered zero flag.
REQ-012 alu_in1, alu_in2  output  32; alu_ct  output  5; alu_shamt  output  5; alu_sign  output  1  operands driven to the shared ALU.
REQ-013 alu_out  input  32; alu_zero  input  1  combinational result from the shared ALU.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-016 In IDLE, with at least one req_valid high, the block SHALL grant exactly one requester, assert its req_ready combinationally in that cycle, latch its operands into the operand registers, and move to EXEC.
REQ-017 req_ready0/1 SHALL be low in every state other than IDLE; neither SHALL assert without the matching req_valid.
REQ-018 A single valid requester SHALL be granted regardless of the priority pointer.
REQ-019 With both valid and FIXED_PRIO=0, the requester not granted most recently SHALL win; the pointer SHALL update only on acceptance.
REQ-020 With FIXED_PRIO=1, port 0 SHALL win every tie.
REQ-021 alu_* outputs SHALL be driven directly from the operand registers, which hold their value outside of acceptance.
REQ-022 In EXEC, the block SHALL capture alu_out into rsp_data and alu_zero into rsp_zero at the clock edge, then move to RESP.
REQ-023 In RESP, rsp_valid SHALL be high for the granted port only; the block SHALL stay in RESP until that port's rsp_ready is high, then return to IDLE.
REQ-024 rsp_ready of the non-granted port SHALL be ignored.
REQ-025 Minimum latency SHALL be: accept at cycle N, rsp_valid high at cycle N+2; peak throughput SHALL be one operation per 3 cycles.
REQ-026 A requester lowering req_valid before being accepted SHALL cause no state change.
REQ-027 rsp_data and rsp_zero SHALL hold stable throughout RESP.

Reset
REQ-028 While reset is high, the FSM SHALL be in IDLE and the pointer SHALL favour port 0.
REQ-029 While reset is high, the operand registers, rsp_data and rsp_zero SHALL be 0, and rsp_valid0/1, req_ready0/1 and busy SHALL be 0.
REQ-030 Reset asserted mid-operation in EXEC or RESP SHALL abort the operation with no response issued.

Verification
REQ-031 Only port 0 valid, in1=5, in2=3, ct=00010: req_ready0 at cycle N, rsp_valid0 at N+2, rsp_data=8, rsp_zero=0.
REQ-032 Both ports valid every cycle for 4 operations, FIXED_PRIO=0: grants alternate 0,1,0,1; with FIXED_PRIO=1, all 4 grants go to port 0.
REQ-033 Port 1 requests ct=00110, in1=in2=7, and holds rsp_ready1 low for 5 cycles: rsp_valid1 and rsp_zero=1 stay stable, busy=1, and port 0 is not accepted until after the release.
REQ-034 Signed compare, in1=0xFFFFFFFF, in2=1, ct=00111, sign=1: rsp_data=1; with sign=0: rsp_data=0.
REQ-035 Reset pulsed during EXEC: no rsp_valid occurs, all outputs return to 0, and the next tie is granted to port 0.
REQ-036 rsp_ready0 high while port 1's result is pending: the block stays in RESP.
